// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester logic-unit arbiter.
// Used by alu_logic_unit and alu_logic_arb.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR
  } logic_op_e;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_st_e;

  localparam int NUM_REQ    = 2;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/alu_logic_unit.sv
// Shared combinational bitwise logic unit (AND/OR/XOR/NOR).
// No carry or flags; result is exactly DATA_W bits.
module alu_logic_unit
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic_op_e         i_op,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    unique case (i_op)
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_NOR: o_y = ~(i_a | i_b);
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_logic_arb.sv
// Round-robin arbiter feeding one shared logic unit into a response slot.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_logic_arb
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req_valid,
  output logic [NUM_REQ-1:0] o_req_ready,
  input  logic [1:0]         i_req_op0,
  input  logic [1:0]         i_req_op1,
  input  logic [DATA_W-1:0]  i_req_a0,
  input  logic [DATA_W-1:0]  i_req_b0,
  input  logic [DATA_W-1:0]  i_req_a1,
  input  logic [DATA_W-1:0]  i_req_b1,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [DATA_W-1:0]  o_rsp_data,
  output logic               o_rsp_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   o_grant_cnt0,
  output logic [CNT_W-1:0]   o_grant_cnt1
`endif
);

  slot_st_e             r_state;
  slot_st_e             w_state_nxt;
  logic                 r_prio;
  logic [DATA_W-1:0]    r_data;
  logic                 r_id;

  logic                 w_slot_free;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_xfer;
  logic                 w_sel;
  logic [DATA_W-1:0]    w_a;
  logic [DATA_W-1:0]    w_b;
  logic_op_e            w_op;
  logic [DATA_W-1:0]    w_y;

  assign w_slot_free = (r_state == SLOT_EMPTY) | i_rsp_ready;

  // Ready is held low during reset even though the slot reads empty.
  always_comb begin
    w_grant = '0;
    if (i_rst_n && w_slot_free) begin
      unique case (i_req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
        default: w_grant = '0;
      endcase
    end
  end

  assign w_xfer = |w_grant;
  assign w_sel  = w_grant[1];
  assign w_a    = w_sel ? i_req_a1 : i_req_a0;
  assign w_b    = w_sel ? i_req_b1 : i_req_b0;
  assign w_op   = logic_op_e'(w_sel ? i_req_op1 : i_req_op0);

  alu_logic_unit #(
    .DATA_W (DATA_W)
  ) u_lu (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_op (w_op),
    .o_y  (w_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SLOT_EMPTY: if (w_xfer) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (i_rsp_ready && !w_xfer) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SLOT_EMPTY;
      r_prio  <= 1'b0;
      r_data  <= '0;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_data <= w_y;
        r_id   <= w_sel;
        r_prio <= ~w_sel;
      end
    end
  end

  assign o_req_ready = w_grant;
  assign o_rsp_valid = (r_state == SLOT_FULL);
  assign o_rsp_data  = r_data;
  assign o_rsp_id    = r_id;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_grant[0] && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_grant[1] && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign o_grant_cnt0 = r_cnt0;
  assign o_grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_logic_arb.sv
// Directed self-checking bench for alu_logic_arb.
// Counter vectors run only when ALU_ARB_STATS_EN is defined.
module tb_alu_logic_arb;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          i_clk;
  logic          i_rst_n;
  logic [1:0]    i_req_valid;
  logic [1:0]    o_req_ready;
  logic [1:0]    i_req_op0;
  logic [1:0]    i_req_op1;
  logic [DW-1:0] i_req_a0;
  logic [DW-1:0] i_req_b0;
  logic [DW-1:0] i_req_a1;
  logic [DW-1:0] i_req_b1;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_id;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] o_grant_cnt0;
  logic [CW-1:0] o_grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  alu_logic_arb #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op0   (i_req_op0),
    .i_req_op1   (i_req_op1),
    .i_req_a0    (i_req_a0),
    .i_req_b0    (i_req_b0),
    .i_req_a1    (i_req_a1),
    .i_req_b1    (i_req_b1),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_id    (o_rsp_id)
`ifdef ALU_ARB_STATS_EN
    ,
    .o_grant_cnt0 (o_grant_cnt0),
    .o_grant_cnt1 (o_grant_cnt1)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #3;
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_req_valid = 2'b11;
    i_req_op0   = 2'b00;
    i_req_op1   = 2'b00;
    i_req_a0    = '0;
    i_req_b0    = '0;
    i_req_a1    = '0;
    i_req_b1    = '0;
    i_rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(o_req_ready), 32'h0);
    chk("rst_valid", 32'(o_rsp_valid), 32'h0);
    chk("rst_data",  o_rsp_data, 32'h0);
    chk("rst_id",    32'(o_rsp_id), 32'h0);
    i_rst_n = 1'b1;

    // single OR request from requester 0
    i_req_valid = 2'b01;
    i_req_op0   = 2'b01;
    i_req_a0    = 32'h0F0F0000;
    i_req_b0    = 32'h000000F0;
    #1;
    chk("or_ready", 32'(o_req_ready), 32'h1);
    tick();
    chk("or_valid", 32'(o_rsp_valid), 32'h1);
    chk("or_data",  o_rsp_data, 32'h0F0F00F0);
    chk("or_id",    32'(o_rsp_id), 32'h0);

    // alternate grants after a fresh reset
    i_req_valid = 2'b00;
    do_reset();
    i_req_valid = 2'b11;
    i_req_op0   = 2'b00;
    i_req_a0    = 32'hFFFF0000;
    i_req_b0    = 32'h00FFFF00;
    i_req_op1   = 2'b10;
    i_req_a1    = 32'hAAAAAAAA;
    i_req_b1    = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_ready", 32'(o_req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("alt_valid", 32'(o_rsp_valid), 32'h1);
      chk("alt_id",    32'(o_rsp_id), (i % 2 == 0) ? 32'h0 : 32'h1);
      chk("alt_data",  o_rsp_data,
          (i % 2 == 0) ? 32'h00FF0000 : 32'h55555555);
    end

    // backpressure: slot holds id1 result
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(o_req_ready), 32'h0);
      tick();
      chk("bp_valid", 32'(o_rsp_valid), 32'h1);
      chk("bp_data",  o_rsp_data, 32'h55555555);
      chk("bp_id",    32'(o_rsp_id), 32'h1);
    end
    i_rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(o_req_ready), 32'h1);
    tick();
    chk("bp_rel_valid", 32'(o_rsp_valid), 32'h1);
    chk("bp_rel_id",    32'(o_rsp_id), 32'h0);
    chk("bp_rel_data",  o_rsp_data, 32'h00FF0000);

    // NOR from requester 1 alone
    i_req_valid = 2'b10;
    i_req_op1   = 2'b11;
    i_req_a1    = 32'h00000000;
    i_req_b1    = 32'h0000FFFF;
    #1;
    chk("nor_ready", 32'(o_req_ready), 32'h2);
    tick();
    chk("nor_data", o_rsp_data, 32'hFFFF0000);
    chk("nor_id",   32'(o_rsp_id), 32'h1);
    i_req_valid = 2'b11;
    #1;
    chk("nor_prio_ready", 32'(o_req_ready), 32'h1);
    tick();
    chk("nor_prio_id",   32'(o_rsp_id), 32'h0);
    chk("nor_prio_data", o_rsp_data, 32'h00FF0000);

    // drain with no new request
    i_req_valid = 2'b00;
    tick();
    chk("drain_valid", 32'(o_rsp_valid), 32'h0);
    chk("drain_data",  o_rsp_data, 32'h00FF0000);
    chk("drain_id",    32'(o_rsp_id), 32'h0);

    // asynchronous reset while slot is full
    i_req_valid = 2'b10;
    tick();
    i_req_valid = 2'b11;
    i_rsp_ready = 1'b0;
    chk("ar_pre_valid", 32'(o_rsp_valid), 32'h1);
    chk("ar_pre_id",    32'(o_rsp_id), 32'h1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(o_rsp_valid), 32'h0);
    chk("ar_data",  o_rsp_data, 32'h0);
    chk("ar_id",    32'(o_rsp_id), 32'h0);
    chk("ar_ready", 32'(o_req_ready), 32'h0);
    tick();
    i_rst_n     = 1'b1;
    i_rsp_ready = 1'b1;
    #1;
    chk("ar_post_ready", 32'(o_req_ready), 32'h1);
    tick();
    chk("ar_post_id",   32'(o_rsp_id), 32'h0);
    chk("ar_post_data", o_rsp_data, 32'h00FF0000);

`ifdef ALU_ARB_STATS_EN
    i_req_valid = 2'b00;
    do_reset();
    chk("cnt_rst0", 32'(o_grant_cnt0), 32'h0);
    chk("cnt_rst1", 32'(o_grant_cnt1), 32'h0);
    i_req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cnt0", 32'(o_grant_cnt0), (i < 3) ? 32'(i + 1) : 32'h3);
      chk("cnt1", 32'(o_grant_cnt1), 32'h0);
    end
    i_req_valid = 2'b00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_logic_arb.md
# alu_logic_arb

Two-requester arbiter and sequencer for one shared 32-bit bitwise logic unit (AND/OR/XOR/NOR) in the execute stage. Each requester presents operands and an opcode on a valid/ready channel. The block grants one request per cycle, round-robin, and evaluates it on the single shared logic unit. It returns the registered result on one response channel tagged with the requester id.

## Interface

Parameters:
- DATA_W, 32, operand/result width
- CNT_W, 16, width of grant counters (used only when ALU_ARB_STATS_EN defined)

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_req_valid  input  2  per-requester request valid (bit r = requester r)
- o_req_ready  output  2  per-requester grant; transfer when valid[r] & ready[r]
- i_req_op0, i_req_op1  input  2 each  opcode: 00 AND, 01 OR, 10 XOR, 11 NOR
- i_req_a0, i_req_b0, i_req_a1, i_req_b1  input  DATA_W each  operands
- o_rsp_valid  output  1  response slot holds a result
- i_rsp_ready  input  1  consumer accepts response
- o_rsp_data  output  DATA_W  result
- o_rsp_id  output  1  requester that issued the result
- o_grant_cnt0, o_grant_cnt1  output  CNT_W each  accepted-request counters (ALU_ARB_STATS_EN only)

## Operation

- Response slot states: EMPTY (o_rsp_valid=0), FULL (o_rsp_valid=1).
- slot_free = EMPTY | (FULL & i_rsp_ready).
- Priority pointer prio (1 bit) names the favoured requester.
- Grant, combinational, when slot_free:
  - Only one valid requester: grant it.
  - Both valid: grant prio.
  - No grant when !slot_free.
  - o_req_ready is one-hot or zero. It may depend on i_req_valid. Requesters must not make valid depend on ready.
- On transfer of requester r:
  - Result of the selected op on a_r/b_r is loaded into o_rsp_data.
  - o_rsp_id <= r, slot -> FULL, prio <= ~r.
- Transitions:
  - FULL & i_rsp_ready & no transfer -> EMPTY; data/id hold their last value.
  - FULL & !i_rsp_ready -> FULL; data/id stable and no grant issued (backpressure).
- prio changes only on a transfer. An idle requester does not steal priority.
- Result width is exactly DATA_W; no carry or flags. NOR = ~(a|b).
- A request held valid without ready must keep op/operands stable until transfer.

## Timing

- Reset values:
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, prio=0 (requester 0 favoured).
  - o_req_ready=0 while i_rst_n low.
  - Counters 0.
- Latency: request accepted at edge N produces o_rsp_valid=1 with data after edge N, i.e. visible in cycle N+1.
- Throughput: one result per cycle when i_rsp_ready held high. A drain and a new load in the same edge are allowed; no bubble.
- Both requesters continuously valid with consumer always ready: grants alternate 0,1,0,1… starting with 0 after reset.
- Reset asserted mid-operation clears the slot immediately, without waiting for the clock. A pending response is discarded, not replayed.

## Configuration

- ALU_ARB_STATS_EN defined:
  - o_grant_cnt0/o_grant_cnt1 exist.
  - Each increments by 1 on every transfer from its requester.
  - Saturates at 2^CNT_W-1; no wrap.
  - Reset to 0.
- Not defined: ports and counter logic absent; behaviour otherwise identical.

## Structure

- Package alu_arb_pkg contains:
  - typedef enum logic [1:0] logic_op_e {OP_AND, OP_OR, OP_XOR, OP_NOR}
  - localparam NUM_REQ = 2
  - default DATA_W constant
- Sub-module alu_logic_unit: purely combinational, inputs a, b, op (logic_op_e), output y. Instantiated once, fed by the grant mux; its output drives the response register.
- The arbiter, slot register, pointer and counters live in the top module.

## Test plan

- Reset, then req0 valid, op=OR, a=0x0F0F0000, b=0x000000F0, rsp_ready=1 -> ready0=1 same cycle; next cycle rsp_valid=1, data=0x0F0F00F0, id=0.
- Both valid every cycle (req0 op=AND, a=0xFFFF0000, b=0x00FFFF00; req1 op=XOR, a=0xAAAAAAAA, b=0xFFFFFFFF) with rsp_ready=1 -> ids alternate 0,1,0,1; data alternate 0x00FF0000 and 0x55555555; one response every cycle.
- rsp_ready=0 for 3 cycles with slot FULL and both valid -> o_req_ready=0 and data/id stable for those cycles. When rsp_ready goes 1, the slot drains and a new grant occurs in the same cycle.
- req1 op=NOR, a=0x00000000, b=0x0000FFFF -> data=0xFFFF0000, id=1. prio then favours 0: next simultaneous request grants 0.
- Assert i_rst_n low between clock edges while rsp_valid=1 -> o_rsp_valid, o_rsp_data and o_rsp_id go to 0 immediately. After release, first simultaneous request grants requester 0.
- ALU_ARB_STATS_EN, CNT_W=2: five grants to req0 -> o_grant_cnt0 reads 1,2,3,3,3; o_grant_cnt1 stays 0.
